// File: rtl/approx_add_pipe.sv
// Pipelined approximate unsigned adder: B-LSB passthrough below APPROX_BITS, segmented carry chain, valid/ready flow control.
// Define ERR_STATS_EN to add the error-statistics ports (stats_clr, err_cnt, err_max) and their logic.
module approx_add_pipe #(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 1,
    parameter int STAGES      = 2,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 approx_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH:0]       sum,
    output logic                 out_approx
`ifdef ERR_STATS_EN
    ,
    input  logic                 stats_clr,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [((APPROX_BITS > 0) ? APPROX_BITS : 1)-1:0] err_max
`endif
);

    localparam int EW  = (APPROX_BITS > 0) ? APPROX_BITS : 1;
    localparam int SEG = (WIDTH + STAGES - 1) / STAGES;
    localparam logic [WIDTH-1:0] LSB_MASK = WIDTH'((64'd1 << APPROX_BITS) - 64'd1);

    if (WIDTH < 2 || APPROX_BITS < 0 || APPROX_BITS > WIDTH - 1 ||
        STAGES < 1 || STAGES > WIDTH || CNT_W < 1) begin : g_bad_params
        $error("approx_add_pipe: illegal parameter combination");
    end

    // Zeroing A's low bits makes an exact add produce the approximate result:
    // B's LSBs pass through and no carry can reach bit k.
    logic [WIDTH-1:0] a_in;
    assign a_in = approx_en ? (a & ~LSB_MASK) : a;

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] adv;
    logic              down_free;

    // Stage j advances when full and the stage below is empty or advancing.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        adv       = '0;
        down_free = out_ready;
        for (int j = STAGES - 1; j >= 0; j--) begin
            adv[j]    = valid_q[j] & down_free;
            down_free = ~valid_q[j] | adv[j];
        end
    end

    assign in_ready = ~valid_q[0] | adv[0];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        localparam int LO = (i * SEG < WIDTH) ? i * SEG : WIDTH;
        localparam int HI = ((i + 1) * SEG < WIDTH) ? (i + 1) * SEG : WIDTH;
        localparam logic [WIDTH:0] MASK = (WIDTH+1)'((64'd1 << (HI - LO)) - 64'd1);

        logic [WIDTH-1:0] a_src, b_src, s_src;
        logic             c_src, ap_src, load;
        logic [WIDTH:0]   seg;
        logic [WIDTH-1:0] s_r;
        logic             c_r, ap_r, v_r;
`ifdef ERR_STATS_EN
        logic [EW-1:0]    err_src, err_r;
`endif

        if (i == 0) begin : g_head
            assign a_src  = a_in;
            assign b_src  = b;
            assign s_src  = '0;
            assign c_src  = 1'b0;
            assign ap_src = approx_en;
            assign load   = in_valid & in_ready;
`ifdef ERR_STATS_EN
            // Error (exact - approx) is exactly the A bits that were dropped.
            assign err_src = approx_en ? EW'(a & LSB_MASK) : '0;
`endif
        end else begin : g_body
            assign a_src  = g_stage[i-1].g_ops.a_r;
            assign b_src  = g_stage[i-1].g_ops.b_r;
            assign s_src  = g_stage[i-1].s_r;
            assign c_src  = g_stage[i-1].c_r;
            assign ap_src = g_stage[i-1].ap_r;
            assign load   = adv[i-1];
`ifdef ERR_STATS_EN
            assign err_src = g_stage[i-1].err_r;
`endif
        end

        assign seg = (({1'b0, a_src} >> LO) & MASK) + (({1'b0, b_src} >> LO) & MASK)
                   + {{WIDTH{1'b0}}, c_src};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_r <= 1'b0;
            end else begin
                // NOTE: state updates use non-blocking assignments so every stage samples pre-edge values.
                v_r <= load | (v_r & ~adv[i]);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            // NOTE: datapath registers are reset as well so sum/out_approx read 0 out of reset.
            if (rst) begin
                s_r  <= '0;
                c_r  <= 1'b0;
                ap_r <= 1'b0;
            end else if (load) begin
                s_r  <= s_src | WIDTH'((seg & MASK) << LO);
                c_r  <= seg[HI-LO];
                ap_r <= ap_src;
            end
        end

        // Operands are only carried forward where a later stage still consumes them.
        if (i < STAGES - 1) begin : g_ops
            logic [WIDTH-1:0] a_r, b_r;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (load) begin
                    a_r <= a_src;
                    b_r <= b_src;
                end
            end
        end

`ifdef ERR_STATS_EN
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                err_r <= '0;
            end else if (load) begin
                err_r <= err_src;
            end
        end
`endif

        assign valid_q[i] = v_r;
    end

    assign out_valid  = valid_q[STAGES-1];
    assign sum        = {g_stage[STAGES-1].c_r, g_stage[STAGES-1].s_r};
    assign out_approx = g_stage[STAGES-1].ap_r;

`ifdef ERR_STATS_EN
    logic [EW-1:0] out_err;
    assign out_err = g_stage[STAGES-1].err_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
            err_max <= '0;
        end else if (stats_clr) begin
            err_cnt <= '0;
            err_max <= '0;
        end else if (out_valid && out_ready && out_approx && out_err != '0) begin
            if (err_cnt != {CNT_W{1'b1}}) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
            if (out_err > err_max) begin
                err_max <= out_err;
            end
        end
    end
`endif

endmodule

// File: tb/tb_approx_add_pipe.sv
// Self-checking bench for approx_add_pipe: dut (k=1, 2 stages) and dut3 (k=3, 3 stages) against an arithmetic model.
module tb_approx_add_pipe;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic         in_valid   [2];
    logic         in_ready   [2];
    logic [W-1:0] a          [2];
    logic [W-1:0] b          [2];
    logic         approx_en  [2];
    logic         out_valid  [2];
    logic         out_ready  [2];
    logic [W:0]   sum        [2];
    logic         out_approx [2];
`ifdef ERR_STATS_EN
    logic         stats_clr  [2];
    logic [15:0]  err_cnt0, err_cnt1;
    logic [0:0]   err_max0;
    logic [2:0]   err_max1;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [W+1:0] q [$];

    always #5 clk = ~clk;

    approx_add_pipe #(.WIDTH(W), .APPROX_BITS(1), .STAGES(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[0]), .b(b[0]), .approx_en(approx_en[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .sum(sum[0]), .out_approx(out_approx[0])
`ifdef ERR_STATS_EN
        , .stats_clr(stats_clr[0]), .err_cnt(err_cnt0), .err_max(err_max0)
`endif
    );

    approx_add_pipe #(.WIDTH(W), .APPROX_BITS(3), .STAGES(3), .CNT_W(16)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[1]), .b(b[1]), .approx_en(approx_en[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .sum(sum[1]), .out_approx(out_approx[1])
`ifdef ERR_STATS_EN
        , .stats_clr(stats_clr[1]), .err_cnt(err_cnt1), .err_max(err_max1)
`endif
    );

    function automatic int k_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int stages_of(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    // Approximate result = exact sum minus the low k bits of A.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ap, input int k);
        int full, lsb;
        full = int'(x) + int'(y);
        lsb  = int'(x) % (1 << k);
        return (W+1)'(ap ? full - lsb : full);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (out_valid[d] !== 1'b0) begin
                n_bad++; $display("FAIL reset_out_valid dut%0d: got %b want 0", d, out_valid[d]);
            end
            n_cmp++;
            if (sum[d] !== '0) begin
                n_bad++; $display("FAIL reset_sum dut%0d: got %h want 000", d, sum[d]);
            end
            n_cmp++;
            if (out_approx[d] !== 1'b0) begin
                n_bad++; $display("FAIL reset_out_approx dut%0d: got %b want 0", d, out_approx[d]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (in_ready[d] !== 1'b1) begin
                n_bad++; $display("FAIL reset_in_ready dut%0d: got %b want 1", d, in_ready[d]);
            end
        end
    endtask

    task automatic test_directed(input int d, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ap, input logic [W:0] exp, input string name);
        int lat;
        @(posedge clk); #1;
        in_valid[d] = 1'b1; a[d] = x; b[d] = y; approx_en[d] = ap; out_ready[d] = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready[d] !== 1'b1) begin
            n_bad++; $display("FAIL %s_accept: in_ready got %b want 1", name, in_ready[d]);
        end
        @(posedge clk); #1;
        in_valid[d] = 1'b0; a[d] = 'x; b[d] = 'x; approx_en[d] = 1'bx;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (out_valid[d] !== 1'b1 && lat < 20);
        n_cmp++;
        if (lat != stages_of(d)) begin
            n_bad++; $display("FAIL %s_latency: got %0d cycles want %0d", name, lat, stages_of(d));
        end
        n_cmp++;
        if (sum[d] !== exp) begin
            n_bad++; $display("FAIL %s_sum: got %h want %h", name, sum[d], exp);
        end
        n_cmp++;
        if (out_approx[d] !== ap) begin
            n_bad++; $display("FAIL %s_out_approx: got %b want %b", name, out_approx[d], ap);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid[d] !== 1'b0) begin
            n_bad++; $display("FAIL %s_no_dup: out_valid got %b want 0", name, out_valid[d]);
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0, got = 0, cyc = 0;
        logic [W+1:0] exp;
        logic stalled = 1'b0;
        logic [W:0] held = '0;
        logic want_ready;
        q.delete();
        while (got < 10 && cyc < 200) begin
            @(posedge clk); #1;
            in_valid[0]  = (sent < 10);
            a[0]         = W'($urandom);
            b[0]         = W'($urandom);
            approx_en[0] = 1'($urandom);
            out_ready[0] = !(cyc >= 3 && cyc <= 6);
            @(negedge clk);
            want_ready = (q.size() < 2) || out_ready[0];
            n_cmp++;
            if (in_ready[0] !== want_ready) begin
                n_bad++; $display("FAIL b2b_in_ready cyc%0d: got %b want %b", cyc, in_ready[0], want_ready);
            end
            if (stalled) begin
                n_cmp++;
                if (sum[0] !== held) begin
                    n_bad++; $display("FAIL b2b_stall_hold cyc%0d: got %h want %h", cyc, sum[0], held);
                end
            end
            stalled = out_valid[0] && !out_ready[0];
            held    = sum[0];
            if (out_valid[0] && out_ready[0]) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL b2b_unexpected cyc%0d: got %h want nothing", cyc, sum[0]);
                end else begin
                    exp = q.pop_front();
                    if ({out_approx[0], sum[0]} !== exp) begin
                        n_bad++; $display("FAIL b2b_result %0d: got %h want %h", got, {out_approx[0], sum[0]}, exp);
                    end
                    got++;
                end
            end
            if (in_valid[0] && in_ready[0]) begin
                q.push_back({approx_en[0], model(a[0], b[0], approx_en[0], 1)});
                sent++;
            end
            cyc++;
        end
        n_cmp++;
        if (got != 10 || q.size() != 0) begin
            n_bad++; $display("FAIL b2b_count: got %0d results want 10 (pending %0d)", got, q.size());
        end
        in_valid[0] = 1'b0; out_ready[0] = 1'b1;
    endtask

    task automatic test_reset_midflight();
        logic stale = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b1; a[0] = 8'h11; b[0] = 8'h22; approx_en[0] = 1'b0; out_ready[0] = 1'b0;
        @(posedge clk); #1;
        a[0] = 8'h33; b[0] = 8'h44;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid[0] !== 1'b0 || sum[0] !== '0) begin
            n_bad++; $display("FAIL midreset_flush: out_valid %b sum %h want 0 000", out_valid[0], sum[0]);
        end
        @(posedge clk); #1;
        rst = 1'b0; out_ready[0] = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (out_valid[0] !== 1'b0) stale = 1'b1;
        end
        n_cmp++;
        if (stale) begin
            n_bad++; $display("FAIL midreset_stale: out_valid got 1 want 0 after reset");
        end
        test_directed(0, 8'h03, 8'h05, 1'b1, 9'h007, "post_reset");
    endtask

    task automatic test_random(input int d, input int n);
        int sent = 0, got = 0, cyc = 0;
        logic [W+1:0] exp;
        q.delete();
        while (got < n && cyc < 20 * n) begin
            @(posedge clk); #1;
            in_valid[d]  = (sent < n) && ($urandom_range(3) != 0);
            a[d]         = W'($urandom);
            b[d]         = W'($urandom);
            approx_en[d] = ($urandom_range(3) != 0);
            out_ready[d] = 1'($urandom);
            @(negedge clk);
            if (out_valid[d] && out_ready[d]) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL rand%0d_unexpected: got %h want nothing", d, sum[d]);
                end else begin
                    exp = q.pop_front();
                    if ({out_approx[d], sum[d]} !== exp) begin
                        n_bad++; $display("FAIL rand%0d_result %0d: got %h want %h", d, got, {out_approx[d], sum[d]}, exp);
                    end
                    got++;
                end
            end
            if (in_valid[d] && in_ready[d]) begin
                q.push_back({approx_en[d], model(a[d], b[d], approx_en[d], k_of(d))});
                sent++;
            end
            cyc++;
        end
        n_cmp++;
        if (got != n || q.size() != 0) begin
            n_bad++; $display("FAIL rand%0d_count: got %0d results want %0d", d, got, n);
        end
        in_valid[d] = 1'b0; out_ready[d] = 1'b1;
    endtask

`ifdef ERR_STATS_EN
    task automatic test_stats();
        @(posedge clk); #1 stats_clr[0] = 1'b1;
        @(posedge clk); #1 stats_clr[0] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (err_cnt0 !== 16'd0 || err_max0 !== 1'b0) begin
            n_bad++; $display("FAIL stats_init_clear: cnt %0d max %0d want 0 0", err_cnt0, err_max0);
        end
        test_directed(0, 8'h03, 8'h05, 1'b1, 9'h007, "stats_a");
        test_directed(0, 8'h02, 8'h05, 1'b1, 9'h007, "stats_b");
        test_directed(0, 8'h01, 8'h01, 1'b1, 9'h001, "stats_c");
        n_cmp++;
        if (err_cnt0 !== 16'd2 || err_max0 !== 1'b1) begin
            n_bad++; $display("FAIL stats_count: cnt %0d max %0d want 2 1", err_cnt0, err_max0);
        end
        test_directed(0, 8'h03, 8'h05, 1'b0, 9'h008, "stats_exact");
        n_cmp++;
        if (err_cnt0 !== 16'd2 || err_max0 !== 1'b1) begin
            n_bad++; $display("FAIL stats_exact_hold: cnt %0d max %0d want 2 1", err_cnt0, err_max0);
        end
        @(posedge clk); #1 stats_clr[0] = 1'b1;
        @(posedge clk); #1 stats_clr[0] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (err_cnt0 !== 16'd0 || err_max0 !== 1'b0) begin
            n_bad++; $display("FAIL stats_clear: cnt %0d max %0d want 0 0", err_cnt0, err_max0);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0; a[d] = '0; b[d] = '0; approx_en[d] = 1'b0; out_ready[d] = 1'b1;
`ifdef ERR_STATS_EN
            stats_clr[d] = 1'b0;
`endif
        end
        test_reset();
        test_directed(0, 8'h03, 8'h05, 1'b1, 9'h007, "d_035_approx");
        test_directed(0, 8'h03, 8'h05, 1'b0, 9'h008, "d_035_exact");
        test_directed(0, 8'hFF, 8'hFF, 1'b1, 9'h1FD, "d_ff_approx");
        test_directed(0, 8'hFF, 8'hFF, 1'b0, 9'h1FE, "d_ff_exact");
        test_directed(0, 8'h80, 8'h80, 1'b1, 9'h100, "d_80_carry");
        test_directed(1, 8'h03, 8'h05, 1'b1, 9'h005, "k3_035_approx");
        test_directed(1, 8'hFF, 8'hFF, 1'b1, 9'h1F7, "k3_ff_approx");
        test_back_to_back();
        test_reset_midflight();
        test_random(0, 1500);
        test_random(1, 1500);
`ifdef ERR_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/approx_add_pipe.md
Name: approx_add_pipe

Overview:
- Parametrised, pipelined successor to the team's 8-bit LSB-passthrough approximate unsigned adder.
- Width, number of approximate LSBs and pipeline depth are generic.
- Exact/approximate mode is selectable per transaction, with valid/ready flow control.
- Sits in the approximate-datapath library, between operand producers and accumulator/MAC consumers in FPGA accelerator fabrics.

Parameters:
WIDTH, 8, operand width in bits (>=2)
APPROX_BITS, 1, number of LSBs computed approximately (0..WIDTH-1; 0 = always exact)
STAGES, 2, pipeline register stages = latency in cycles (1..WIDTH)
CNT_W, 16, width of error-statistics counter (used only with ERR_STATS_EN)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  operand transaction valid
in_ready  out  1  block can accept a transaction this cycle
a  in  WIDTH  operand A, unsigned
b  in  WIDTH  operand B, unsigned
approx_en  in  1  1 = approximate sum, 0 = exact sum; sampled with the transaction
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
sum  out  WIDTH+1  result, unsigned, including carry-out
out_approx  out  1  approx_en value carried with this result
stats_clr  in  1  ERR_STATS_EN only: synchronous clear of statistics
err_cnt  out  CNT_W  ERR_STATS_EN only: count of results where approx != exact
err_max  out  max(APPROX_BITS,1)  ERR_STATS_EN only: largest absolute error seen

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all stage valid flags 0, out_valid=0, sum=0, out_approx=0, err_cnt=0, err_max=0. in_ready=1 combinationally once rst is low.
- Exact mode: sum = a + b, full WIDTH+1 bits. No wrap.
- Approximate mode, k=APPROX_BITS:
  - sum[k-1:0] = b[k-1:0], a passthrough of B LSBs.
  - Carry into bit k is forced to 0.
  - sum[WIDTH:k] = a[WIDTH-1:k] + b[WIDTH-1:k].
  - Required identity: approx sum = exact sum - a[k-1:0]. Error is always >=0 and WCE = 2^k-1.
  - k=0 makes approximate mode identical to exact mode.
- Pipelining:
  - The carry chain is split into STAGES segments of ceil(WIDTH/STAGES) bits, LSB segment first; the last segment may be narrower.
  - Stage i registers its segment's partial sum and carry-out, plus the still-unprocessed operand bits and approx_en.
  - Latency is exactly STAGES cycles from input handshake to out_valid when there is no stall.
- Handshake:
  - Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
  - Stage j advances when it holds data and (stage j+1 is empty or advancing). The last stage advances on out_ready.
  - in_ready = stage 0 empty or stage 0 advancing; it is combinational from out_ready through the chain.
  - Bubbles collapse: an empty stage accepts data even while downstream is stalled.
  - Throughput is 1 result/cycle while out_ready=1.
  - sum and out_approx hold stable while out_valid & !out_ready.
  - No data may be dropped or duplicated.
- Simultaneous events: a full pipeline with out_ready=1 accepts a new input in the same cycle the last result leaves.
- Reset mid-operation: all in-flight transactions are discarded immediately (async); nothing is emitted after reset deasserts until new inputs arrive.
- Inputs a, b and approx_en are don't-care when in_valid=0. X on them must not propagate into valid flags.

Optional Feature:
- Macro ERR_STATS_EN.
- When defined:
  - The block also computes the exact sum alongside each result.
  - On every output handshake with out_approx=1 and a nonzero error, err_cnt increments, saturating at 2^CNT_W-1.
  - err_max updates to max(err_max, error).
  - stats_clr zeroes both on the next edge. stats_clr has priority over a same-cycle update.
  - Ports stats_clr, err_cnt and err_max exist.
- When not defined: these ports and all associated logic are absent. Datapath behaviour is identical.

Test Plan:
- Config WIDTH=8, APPROX_BITS=1, STAGES=2, out_ready=1. a=0x03, b=0x05, approx_en=1 -> sum=0x007, out_valid exactly 2 cycles after the handshake. Same operands with approx_en=0 -> 0x008.
- a=0xFF, b=0xFF: approx -> 0x1FD, exact -> 0x1FE. a=0x80, b=0x80, approx -> 0x100, checking the carry-out.
- Stream 10 back-to-back inputs while out_ready is held 0 for cycles 3-6. All 10 results must appear in order with no loss. in_ready drops only when both stages are full. sum stays stable during the stall.
- Assert rst while 2 transactions are in flight -> out_valid=0 immediately. After release, no stale result ever appears. The first new input returns correctly after 2 cycles.
- Sweep all 65536 operand pairs in approx mode with random out_ready. Every result must equal (a+b) - (a & 1). Repeat with APPROX_BITS=3, STAGES=3 and check (a+b) - (a & 7).
- ERR_STATS_EN, APPROX_BITS=1. Send approx pairs (0x03,0x05), (0x02,0x05), (0x01,0x01) -> err_cnt=2, err_max=1. Pulse stats_clr -> both 0 next cycle. Exact-mode traffic leaves both unchanged.
